// File: rtl/div_unit_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state encodings.
// The CPU control FSM decodes these same state values for its DIV wait states.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Control-unit <-> divider signal bundle. The control unit is the master and the divider is the slave.
interface div_unit_if import div_unit_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // One extra bit so the borrow out of the trial subtract shows up as the sign.
  logic [WIDTH:0] diff;

  assign diff = {rem_in, quo_in[WIDTH-1]} - {1'b0, dvs};

  // Keep the difference when it did not borrow, otherwise keep the shifted remainder.
  always_comb begin
    rem_out = {rem_in[WIDTH-2:0], quo_in[WIDTH-1]};
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_out    = diff[WIDTH-1:0];
      quo_out[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider for DIV: quotient to LO, remainder to HI, one quotient bit per cycle.
// Operands are converted to magnitudes at start, divided unsigned, then sign-fixed in a single FIX cycle.
module div_unit import div_unit_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             neg_q, neg_r, dz;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             dvs_zero;

  // -MIN wraps back to MIN, which is the right magnitude when read as unsigned.
  assign dvd_mag  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign dvs_zero = (bus.divisor == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .dvs     (dvs),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; start is only honoured in IDLE, and DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = dvs_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands, iterate, sign-fix into hi/lo, track divide-by-zero flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          if (dvs_zero) begin
            dz <= 1'b1;
          end else begin
            quo   <= dvd_mag;
            dvs   <= dvs_mag;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r <= bus.dividend[WIDTH-1];
          end
        end
        S_CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          lo_q <= neg_q ? -quo : quo;
          hi_q <= neg_r ? -rem : rem;
        end
        S_DONE: dz <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == S_CALC) || (state == S_FIX);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = dz;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {lo,hi,div_zero} queued at start, checked on every done pulse.
module tb_div_unit;

  logic clk = 1'b0;
  logic reset;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t        sbq[$];
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] prev_lo = '0;
  logic [31:0] prev_hi = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: divide 33-bit magnitudes in 64-bit arithmetic, then apply the sign rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint unsigned ma, mb, mq, mr;
    ma = a[31] ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
    mb = b[31] ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
    mq = ma / mb;
    mr = ma % mb;
    q  = (a[31] ^ b[31]) ? -mq[31:0] : mq[31:0];
    r  = a[31] ? -mr[31:0] : mr[31:0];
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("lo", bus.lo, e.lo);
        chk("hi", bus.hi, e.hi);
        chk("div_zero", bus.div_zero, e.dz);
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi);
    exp_t e;
    int   lat, nb;
    logic zero;
    zero = (b == 32'h0);
    e.lo = zero ? prev_lo : elo;
    e.hi = zero ? prev_hi : ehi;
    e.dz = zero;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
    lat = 0; nb = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy) nb++;
      if (lat == 1) begin
        chk("hold_lo", bus.lo, prev_lo);
        chk("hold_hi", bus.hi, prev_hi);
      end
    end while (!bus.done && lat < 60);
    chk("latency", lat, zero ? 1 : 34);
    chk("busy_cycles", nb, zero ? 0 : 33);
    if (!zero) begin
      prev_lo = elo;
      prev_hi = ehi;
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rq, rr;
    int n, seen, last;
    reset = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_zero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    @(negedge clk);
    reset = 1'b1;

    do_op(32'd100, 32'd7, 32'd14, 32'd2);
    do_op(-32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_op(32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1);
    do_op(-32'sd7, -32'sd2, 32'd3, 32'hFFFF_FFFF);
    do_op(32'd100, 32'd7, 32'd14, 32'd2);
    do_op(32'd5, 32'd0, 32'h0, 32'h0);                       // keeps 14/2
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    do_op(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
    do_op(32'd3, 32'd10, 32'd0, 32'd3);
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF);
    do_op(-32'sd9, 32'd0, 32'h0, 32'h0);                     // keeps prior result

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 3) ? $urandom : 32'($urandom_range(1, 1000));
      if (rb == 0) rb = 32'd1;
      ref_div(ra, rb, rq, rr);
      do_op(ra, rb, rq, rr);
    end

    // Abort mid-calculation: a re-pulsed start is ignored, reset clears everything, no done appears.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd20; bus.divisor = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_abort_busy", bus.busy, 0);
    chk("post_abort_lo", bus.lo, 0);
    prev_lo = '0; prev_hi = '0;
    do_op(32'd20, 32'd3, 32'd6, 32'd2);

    // Back-to-back with start held high: IDLE re-samples every 35 edges.
    for (int i = 0; i < 3; i++) sbq.push_back('{lo: 32'd10, hi: 32'd0, dz: 1'b0});
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    n = 0; seen = 0; last = 0;
    while (seen < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        seen++;
        if (seen == 1) chk("b2b_first", n, 34);
        else           chk("b2b_gap", n - last, 35);
        last = n;
        if (seen == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", seen, 3);
    repeat (40) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
